// File: rtl/pe_mac_cell.sv
// Systolic-array processing element: forwards A east / B south, accumulates A*B per framed
// dot product, and shifts finished results along a ready/valid drain chain toward the array edge.
module pe_mac_cell #(
    parameter int DW_A      = 8,
    parameter int DW_B      = 8,
    parameter int ACC_DEPTH = 4,
    parameter int DW_ACC    = DW_A + DW_B + $clog2(ACC_DEPTH),
    parameter int PIPE_MULT = 0,
    parameter int SATURATE  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_mode,
    input  logic [DW_A-1:0]   a_in,
    input  logic              a_valid_in,
    input  logic              first_in,
    input  logic              last_in,
    input  logic [DW_B-1:0]   b_in,
    input  logic              b_valid_in,
    output logic [DW_A-1:0]   a_out,
    output logic              a_valid_out,
    output logic              first_out,
    output logic              last_out,
    output logic [DW_B-1:0]   b_out,
    output logic              b_valid_out,
    input  logic [DW_ACC-1:0] res_in,
    input  logic              res_ovf_in,
    input  logic              res_in_valid,
    output logic              res_in_ready,
    output logic [DW_ACC-1:0] res_out,
    output logic              res_ovf_out,
    output logic              res_out_valid,
    input  logic              res_out_ready,
    output logic              res_drop
);

    localparam int PW     = DW_A + DW_B;
    localparam int XW     = DW_ACC + 1;
    localparam bit SAT_EN = (SATURATE != 0);

    logic              fire_s;
    logic              mode_r;
    logic              mode_cur_s;
    logic [PW-1:0]     a_x_s;
    logic [PW-1:0]     b_x_s;
    logic [PW-1:0]     prod_s;

    logic [PW-1:0]     st_prod_s;
    logic              st_fire_s;
    logic              st_first_s;
    logic              st_last_s;
    logic              st_mode_s;

    logic [DW_ACC-1:0] acc_r;
    logic              ovf_r;
    logic [DW_ACC-1:0] base_s;
    logic [XW-1:0]     base_x_s;
    logic [XW-1:0]     prod_x_s;
    logic [XW-1:0]     sum_s;
    logic              ovf_s;
    logic [DW_ACC-1:0] acc_next_s;
    logic              ovf_next_s;

    logic              loc_v_r;
    logic [DW_ACC-1:0] loc_res_r;
    logic              loc_ovf_r;
    logic              can_load_s;
    logic              take_loc_s;
    logic              done_s;
    logic              keep_new_s;

    assign fire_s = a_valid_in & b_valid_in;

    // Operand/framing forwarding, never stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out       <= {DW_A{1'b0}};
            a_valid_out <= 1'b0;
            first_out   <= 1'b0;
            last_out    <= 1'b0;
            b_out       <= {DW_B{1'b0}};
            b_valid_out <= 1'b0;
        end else begin
            a_out       <= a_in;
            a_valid_out <= a_valid_in;
            first_out   <= first_in;
            last_out    <= last_in;
            b_out       <= b_in;
            b_valid_out <= b_valid_in;
        end
    end

    // Mode held for the whole dot product
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r <= 1'b0;
        end else if (fire_s && first_in) begin
            mode_r <= signed_mode;
        end else begin
            mode_r <= mode_r;
        end
    end

    // Effective mode: the first term already uses the incoming mode
    always_comb begin
        if (fire_s && first_in) begin
            mode_cur_s = signed_mode;
        end else begin
            mode_cur_s = mode_r;
        end
    end

    // Extending operands to full product width makes one multiplier serve both modes
    always_comb begin
        a_x_s  = {{(PW-DW_A){mode_cur_s & a_in[DW_A-1]}}, a_in};
        b_x_s  = {{(PW-DW_B){mode_cur_s & b_in[DW_B-1]}}, b_in};
        prod_s = a_x_s * b_x_s;
    end

    generate
        if (PIPE_MULT != 0) begin : g_pipe
            logic [PW-1:0] prod_r;
            logic          fire_r;
            logic          first_r;
            logic          last_r;
            logic          mode_st_r;

            // Product stage register
            always_ff @(posedge clk) begin
                if (rst) begin
                    prod_r    <= {PW{1'b0}};
                    fire_r    <= 1'b0;
                    first_r   <= 1'b0;
                    last_r    <= 1'b0;
                    mode_st_r <= 1'b0;
                end else begin
                    prod_r    <= prod_s;
                    fire_r    <= fire_s;
                    first_r   <= fire_s & first_in;
                    last_r    <= fire_s & last_in;
                    mode_st_r <= mode_cur_s;
                end
            end

            assign st_prod_s  = prod_r;
            assign st_fire_s  = fire_r;
            assign st_first_s = first_r;
            assign st_last_s  = last_r;
            assign st_mode_s  = mode_st_r;
        end else begin : g_comb
            assign st_prod_s  = prod_s;
            assign st_fire_s  = fire_s;
            assign st_first_s = fire_s & first_in;
            assign st_last_s  = fire_s & last_in;
            assign st_mode_s  = mode_cur_s;
        end
    endgenerate

    // One extra sum bit exposes overflow in both modes
    always_comb begin
        if (st_first_s) begin
            base_s = {DW_ACC{1'b0}};
        end else begin
            base_s = acc_r;
        end
        base_x_s = {st_mode_s & base_s[DW_ACC-1], base_s};
        prod_x_s = {{(XW-PW){st_mode_s & st_prod_s[PW-1]}}, st_prod_s};
        sum_s    = base_x_s + prod_x_s;
        if (st_mode_s) begin
            ovf_s = sum_s[XW-1] ^ sum_s[XW-2];
        end else begin
            ovf_s = sum_s[XW-1];
        end
        if (ovf_s && SAT_EN) begin
            if (!st_mode_s) begin
                acc_next_s = {DW_ACC{1'b1}};
            end else if (sum_s[XW-1]) begin
                acc_next_s = {1'b1, {(DW_ACC-1){1'b0}}};
            end else begin
                acc_next_s = {1'b0, {(DW_ACC-1){1'b1}}};
            end
        end else begin
            acc_next_s = sum_s[DW_ACC-1:0];
        end
        ovf_next_s = (st_first_s ? 1'b0 : ovf_r) | ovf_s;
    end

    // Accumulator and overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {DW_ACC{1'b0}};
            ovf_r <= 1'b0;
        end else if (st_fire_s) begin
            acc_r <= acc_next_s;
            ovf_r <= ovf_next_s;
        end else begin
            acc_r <= acc_r;
            ovf_r <= ovf_r;
        end
    end

    assign can_load_s   = ~res_out_valid | res_out_ready;
    assign take_loc_s   = can_load_s & loc_v_r;
    assign done_s       = st_fire_s & st_last_s;
    assign keep_new_s   = done_s & (~loc_v_r | take_loc_s);
    assign res_in_ready = can_load_s & ~loc_v_r & ~rst;

    // Local result buffer and sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            loc_v_r   <= 1'b0;
            loc_res_r <= {DW_ACC{1'b0}};
            loc_ovf_r <= 1'b0;
            res_drop  <= 1'b0;
        end else begin
            if (keep_new_s) begin
                loc_v_r   <= 1'b1;
                loc_res_r <= acc_next_s;
                loc_ovf_r <= ovf_next_s;
            end else if (take_loc_s) begin
                loc_v_r   <= 1'b0;
            end else begin
                loc_v_r   <= loc_v_r;
            end
            if (done_s && !keep_new_s) begin
                res_drop <= 1'b1;
            end else begin
                res_drop <= res_drop;
            end
        end
    end

    // Drain register: local result wins over upstream
    always_ff @(posedge clk) begin
        if (rst) begin
            res_out       <= {DW_ACC{1'b0}};
            res_ovf_out   <= 1'b0;
            res_out_valid <= 1'b0;
        end else if (can_load_s) begin
            if (loc_v_r) begin
                res_out       <= loc_res_r;
                res_ovf_out   <= loc_ovf_r;
                res_out_valid <= 1'b1;
            end else if (res_in_valid) begin
                res_out       <= res_in;
                res_ovf_out   <= res_ovf_in;
                res_out_valid <= 1'b1;
            end else begin
                res_out_valid <= 1'b0;
            end
        end else begin
            res_out_valid <= res_out_valid;
        end
    end

endmodule

// File: tb/tb_pe_mac_cell.sv
// Bench for pe_mac_cell: an integer dot-product model feeds expected-result queues that are
// checked every cycle against a saturating PIPE_MULT=0 cell and a wrapping PIPE_MULT=1 cell.
module tb_pe_mac_cell;

    localparam int W = 18;

    typedef struct packed {
        logic [W-1:0] v;
        logic         o;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         signed_mode;
    logic [7:0]   a_in;
    logic         a_valid_in;
    logic         first_in;
    logic         last_in;
    logic [7:0]   b_in;
    logic         b_valid_in;
    logic [7:0]   a_out;
    logic         a_valid_out;
    logic         first_out;
    logic         last_out;
    logic [7:0]   b_out;
    logic         b_valid_out;
    logic [W-1:0] res_in;
    logic         res_ovf_in;
    logic         res_in_valid;
    logic         res_in_ready;
    logic [W-1:0] res_out;
    logic         res_ovf_out;
    logic         res_out_valid;
    logic         res_out_ready;
    logic         res_drop;

    logic [7:0]   w_a_out;
    logic         w_a_valid_out;
    logic         w_first_out;
    logic         w_last_out;
    logic [7:0]   w_b_out;
    logic         w_b_valid_out;
    logic         w_res_in_ready;
    logic [W-1:0] w_res_out;
    logic         w_res_ovf_out;
    logic         w_res_out_valid;
    logic         w_res_drop;

    int     n_chk  = 0;
    int     n_pass = 0;
    res_t   q_main[$];
    res_t   q_wrap[$];
    bit     exp_drop = 1'b0;
    longint m_sat, m_wrap, m_last_sat, m_last_wrap;
    bit     m_mode, m_ovf;
    logic [19:0] fwd_exp;

    always #5 clk = ~clk;

    pe_mac_cell #(.PIPE_MULT(0), .SATURATE(1)) u_dut (
        .clk(clk), .rst(rst), .signed_mode(signed_mode),
        .a_in(a_in), .a_valid_in(a_valid_in), .first_in(first_in), .last_in(last_in),
        .b_in(b_in), .b_valid_in(b_valid_in),
        .a_out(a_out), .a_valid_out(a_valid_out), .first_out(first_out), .last_out(last_out),
        .b_out(b_out), .b_valid_out(b_valid_out),
        .res_in(res_in), .res_ovf_in(res_ovf_in), .res_in_valid(res_in_valid),
        .res_in_ready(res_in_ready), .res_out(res_out), .res_ovf_out(res_ovf_out),
        .res_out_valid(res_out_valid), .res_out_ready(res_out_ready), .res_drop(res_drop)
    );

    pe_mac_cell #(.PIPE_MULT(1), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .signed_mode(signed_mode),
        .a_in(a_in), .a_valid_in(a_valid_in), .first_in(first_in), .last_in(last_in),
        .b_in(b_in), .b_valid_in(b_valid_in),
        .a_out(w_a_out), .a_valid_out(w_a_valid_out), .first_out(w_first_out),
        .last_out(w_last_out), .b_out(w_b_out), .b_valid_out(w_b_valid_out),
        .res_in(18'd0), .res_ovf_in(1'b0), .res_in_valid(1'b0),
        .res_in_ready(w_res_in_ready), .res_out(w_res_out), .res_ovf_out(w_res_ovf_out),
        .res_out_valid(w_res_out_valid), .res_out_ready(1'b1), .res_drop(w_res_drop)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    endtask

    // Expected forwarded values: whatever the cell saw at the last edge
    always @(posedge clk) begin
        fwd_exp <= rst ? 20'd0 : {a_in, a_valid_in, first_in, last_in, b_in, b_valid_in};
    end

    // Model update and per-cycle comparison, on the falling edge
    initial begin : monitor
        bit   hold_m, hold_w;
        res_t hv_m, e;
        longint av, bv, p, hi, lo;
        hold_m = 1'b0;
        hold_w = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q_main.delete();
                q_wrap.delete();
                hold_m = 1'b0;
                hold_w = 1'b0;
            end else begin
                if (hold_m) chk("res_hold", {res_out_valid, res_out, res_ovf_out}, {1'b1, hv_m});
                if (res_out_valid && res_out_ready) begin
                    if (q_main.size() == 0) chk("res_out_unexpected", 64'd1, 64'd0);
                    else begin
                        e = q_main.pop_front();
                        chk("res_out", {res_out, res_ovf_out}, e);
                    end
                end
                hold_m = res_out_valid && !res_out_ready;
                hv_m   = {res_out, res_ovf_out};
                if (w_res_out_valid) begin
                    if (q_wrap.size() == 0) chk("wrap_res_unexpected", 64'd1, 64'd0);
                    else begin
                        e = q_wrap.pop_front();
                        chk("wrap_res_out", {w_res_out, w_res_ovf_out}, e);
                    end
                end
                chk("fwd", {a_out, a_valid_out, first_out, last_out, b_out, b_valid_out}, fwd_exp);
                chk("wrap_fwd", {w_a_out, w_a_valid_out, w_first_out, w_last_out, w_b_out, w_b_valid_out}, fwd_exp);
                if (res_in_valid && res_in_ready) q_main.push_back({res_in, res_ovf_in});
                if (a_valid_in && b_valid_in) begin
                    if (first_in) begin
                        m_mode = signed_mode;
                        m_sat  = 0;
                        m_wrap = 0;
                        m_ovf  = 1'b0;
                    end
                    av = m_mode ? longint'($signed(a_in)) : longint'(a_in);
                    bv = m_mode ? longint'($signed(b_in)) : longint'(b_in);
                    p  = av * bv;
                    hi = m_mode ? 64'sd131071 : 64'sd262143;
                    lo = m_mode ? -64'sd131072 : 64'sd0;
                    m_sat  = m_sat + p;
                    m_wrap = m_wrap + p;
                    if (m_sat > hi) begin m_sat = hi; m_ovf = 1'b1; end
                    else if (m_sat < lo) begin m_sat = lo; m_ovf = 1'b1; end
                    if (m_wrap > hi || m_wrap < lo) begin
                        m_ovf  = 1'b1;
                        m_wrap = m_wrap & 64'sd262143;
                        if (m_mode && m_wrap > 64'sd131071) m_wrap = m_wrap - 64'sd262144;
                    end
                    if (last_in) begin
                        m_last_sat  = m_sat;
                        m_last_wrap = m_wrap;
                        if (exp_drop) exp_drop = 1'b0;
                        else q_main.push_back({m_sat[W-1:0], m_ovf});
                        q_wrap.push_back({m_wrap[W-1:0], m_ovf});
                    end
                end
            end
        end
    end

    task automatic drive(input int a, input bit av, input int b, input bit bv, input bit f, input bit l);
        a_in       = a[7:0];
        a_valid_in = av;
        b_in       = b[7:0];
        b_valid_in = bv;
        first_in   = f;
        last_in    = l;
        @(posedge clk); #1;
    endtask

    task automatic term(input int a, input int b, input bit f, input bit l);
        drive(a, 1'b1, b, 1'b1, f, l);
    endtask

    task automatic idle(input int n);
        a_valid_in = 1'b0;
        b_valid_in = 1'b0;
        first_in   = 1'b0;
        last_in    = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_empty();
        int n;
        idle(0);
        n = 0;
        while ((q_main.size() + q_wrap.size()) != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 64'(q_main.size() + q_wrap.size()), 64'd0);
        idle(2);
    endtask

    task automatic push_up(input int v, input bit o);
        int n;
        res_in       = v[W-1:0];
        res_ovf_in   = o;
        res_in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_in_ready && n < 50);
        chk("up_accept", 64'(res_in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; signed_mode = 1'b0; res_in = 18'd0; res_ovf_in = 1'b0;
        res_in_valid = 1'b0; res_out_ready = 1'b1;
        a_in = 8'd0; b_in = 8'd0; a_valid_in = 1'b0; b_valid_in = 1'b0;
        first_in = 1'b0; last_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(res_in_ready), 64'd0);
        chk("reset_outs", {a_out, a_valid_out, first_out, last_out, b_out, b_valid_out,
                           res_out, res_ovf_out, res_out_valid, res_drop}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_idle", 64'(res_in_ready), 64'd1);
        @(posedge clk); #1;

        // 1: signed framed dot product, exact latency; mode changes mid-product are ignored
        signed_mode = 1'b1;
        term(1, 5, 1'b1, 1'b0);
        signed_mode = 1'b0;
        term(-2, 6, 1'b0, 1'b0);
        term(3, -7, 1'b0, 1'b0);
        term(4, 8, 1'b0, 1'b1);
        idle(0);
        @(negedge clk);
        chk("lat_t1_valid", 64'(res_out_valid), 64'd0);
        @(negedge clk);
        chk("lat_t2_valid", 64'(res_out_valid), 64'd1);
        chk("lat_t2_res", {res_out, res_ovf_out}, {18'd4, 1'b0});
        wait_empty();
        chk("pin_signed_dot", 64'(m_last_sat), 64'(4));

        // 2: unsigned 255*255, four terms fit, five overflow
        signed_mode = 1'b0;
        for (int i = 0; i < 4; i++) term(255, 255, i == 0, i == 3);
        wait_empty();
        chk("pin_u4", 64'(m_last_sat), 64'd260100);
        for (int i = 0; i < 5; i++) term(255, 255, i == 0, i == 4);
        wait_empty();
        chk("pin_u5_sat", 64'(m_last_sat), 64'd262143);
        chk("pin_u5_wrap", 64'(m_last_wrap), 64'd62981);

        // signed positive overflow: 8 x (-128*-128) = 131072
        signed_mode = 1'b1;
        for (int i = 0; i < 8; i++) term(-128, -128, i == 0, i == 7);
        wait_empty();
        chk("pin_s8_sat", 64'(m_last_sat), 64'd131071);
        chk("pin_s8_wrap", 64'(m_last_wrap), 64'(-131072));

        // 3: a_valid gaps with framing traps on non-fire cycles
        drive(1, 1'b1, 2, 1'b1, 1'b1, 1'b0);
        drive(99, 1'b0, 2, 1'b1, 1'b0, 1'b1);
        drive(-3, 1'b1, 4, 1'b1, 1'b0, 1'b0);
        drive(50, 1'b0, 5, 1'b1, 1'b1, 1'b0);
        drive(5, 1'b1, -6, 1'b1, 1'b0, 1'b1);
        wait_empty();
        chk("pin_gaps", 64'(m_last_sat), 64'(-40));

        // 4: backpressure, third result dropped
        signed_mode = 1'b0;
        res_out_ready = 1'b0;
        term(2, 3, 1'b1, 1'b1);
        term(4, 5, 1'b1, 1'b1);
        exp_drop = 1'b1;
        term(7, 1, 1'b1, 1'b1);
        idle(7);
        @(negedge clk);
        chk("bp_drop", 64'(res_drop), 64'd1);
        chk("bp_held", {res_out_valid, res_out}, {1'b1, 18'd6});
        chk("bp_ready", 64'(res_in_ready), 64'd0);
        @(posedge clk); #1;
        res_out_ready = 1'b1;
        wait_empty();

        // 5: upstream chain racing a local result
        fork
            begin
                term(3, 4, 1'b1, 1'b0);
                term(2, 2, 1'b0, 1'b1);
                idle(0);
            end
            begin
                repeat (2) begin @(posedge clk); #1; end
                push_up(1000, 1'b0);
                push_up(2000, 1'b1);
                push_up(3000, 1'b0);
                res_in_valid = 1'b0;
            end
        join
        wait_empty();

        // 6: reset mid-accumulation with a stalled result in the drain
        res_out_ready = 1'b0;
        term(3, 3, 1'b1, 1'b1);
        idle(2);
        @(negedge clk);
        chk("pre_rst_valid", 64'(res_out_valid), 64'd1);
        @(posedge clk); #1;
        signed_mode = 1'b1;
        term(10, 10, 1'b1, 1'b0);
        term(10, 10, 1'b0, 1'b0);
        idle(0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outs", {a_out, a_valid_out, first_out, last_out, b_out, b_valid_out,
                         res_out, res_ovf_out, res_out_valid, res_drop}, 64'd0);
        chk("rst_wrap_valid", 64'(w_res_out_valid), 64'd0);
        @(posedge clk); #1;
        res_out_ready = 1'b1;
        term(2, -3, 1'b1, 1'b0);
        term(4, 5, 1'b0, 1'b1);
        wait_empty();
        chk("pin_post_rst", 64'(m_last_sat), 64'd14);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
